// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_pkg
// Purpose : Shared FSM state encoding and parameter defaults for uart_rx.
// Revision: 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  localparam int c_DEF_DATA_WIDTH = 8;
  localparam int c_DEF_OVERSAMPLE = 16;
  localparam int c_DEF_BAUD_DIV   = 27;
  localparam int c_DEF_PARITY_EN  = 1;
  localparam int c_DEF_PARITY_ODD = 0;
  localparam int c_DEF_STOP_BITS  = 1;

endpackage
`default_nettype wire

// File: rtl/uart_rx_baud_gen.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_baud_gen
// Purpose : Oversample tick generator. Divides pclk by BAUD_DIV while
//           enabled and holds at zero otherwise, so every frame starts
//           with a freshly aligned tick phase.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_baud_gen
  import uart_rx_pkg::*;
#(
  parameter int BAUD_DIV = c_DEF_BAUD_DIV
) (
  input  logic pclk,
  input  logic areset,
  input  logic i_en,
  output logic o_tick
);

  localparam int c_CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BAUD_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;

  // Free-running divider while enabled; parked at zero while idle.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      r_cnt <= '0;
    end else if (!i_en || (r_cnt == c_CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == c_CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Purpose : Oversampling UART receiver with 2-of-3 majority bit decisions,
//           optional parity, 1/2 stop bits and a one-word output holding
//           register with valid/ready handshake and overrun reporting.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int OVERSAMPLE = c_DEF_OVERSAMPLE,
  parameter int BAUD_DIV   = c_DEF_BAUD_DIV,
  parameter int PARITY_EN  = c_DEF_PARITY_EN,
  parameter int PARITY_ODD = c_DEF_PARITY_ODD,
  parameter int STOP_BITS  = c_DEF_STOP_BITS
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int c_OS_W = $clog2(OVERSAMPLE);
  localparam int c_BC_W = $clog2(DATA_WIDTH);
  localparam logic [c_OS_W-1:0] c_OS_S0   = c_OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_OS_W-1:0] c_OS_S1   = c_OS_W'(OVERSAMPLE / 2);
  localparam logic [c_OS_W-1:0] c_OS_S2   = c_OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [c_OS_W-1:0] c_OS_LAST = c_OS_W'(OVERSAMPLE - 1);
  localparam logic [c_BC_W-1:0] c_BIT_LAST  = c_BC_W'(DATA_WIDTH - 1);
  localparam logic [c_BC_W-1:0] c_STOP_LAST = c_BC_W'(STOP_BITS - 1);

  state_t                r_state, w_next;
  logic                  r_rx_meta, r_rx_sync, r_rx_prev;
  logic [c_OS_W-1:0]     r_os_cnt;
  logic [c_BC_W-1:0]     r_bit_cnt;
  logic                  r_s0, r_s1;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bad, r_frm_err;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid, r_perr, r_ferr, r_ovr;

  logic w_tick, w_busy, w_fall, w_maj, w_decide, w_bit_end;
  logic w_frame_done, w_ferr_final, w_load;

  assign w_busy       = (r_state != ST_IDLE);
  assign w_fall       = r_rx_prev & ~r_rx_sync;
  // Third sample is the live synchronized line at the decision tick.
  assign w_maj        = (r_s0 & r_s1) | (r_s0 & r_rx_sync) | (r_s1 & r_rx_sync);
  assign w_decide     = w_tick && (r_os_cnt == c_OS_S2);
  assign w_bit_end    = w_tick && (r_os_cnt == c_OS_LAST);
  assign w_frame_done = (r_state == ST_STOP) && w_decide && (r_bit_cnt == c_STOP_LAST);
  assign w_ferr_final = r_frm_err | ~w_maj;
  // A completed frame is kept only if the holding register is free this cycle.
  assign w_load       = w_frame_done && (!r_valid || rx_ready);

  uart_rx_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .pclk   (pclk),
    .areset (areset),
    .i_en   (w_busy),
    .o_tick (w_tick)
  );

  // Two-flop synchronizer plus one delayed copy for start-edge detection.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // FSM state register.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // FSM next-state logic; stop-bit exit happens at the decision point so the
  // receiver is ready for the next start edge half a bit early.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_fall) w_next = ST_START;
      ST_START: begin
        if (w_decide && w_maj) w_next = ST_IDLE;
        else if (w_bit_end)    w_next = ST_DATA;
      end
      ST_DATA:      if (w_bit_end && (r_bit_cnt == c_BIT_LAST))
                      w_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (w_bit_end) w_next = ST_STOP;
      ST_STOP:      if (w_frame_done) w_next = w_ferr_final ? ST_WAIT_IDLE : ST_IDLE;
      ST_WAIT_IDLE: if (r_rx_sync) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Bit timing, sampling and frame assembly datapath.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
      r_frm_err <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_par_bad <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      if (w_tick) r_os_cnt <= (r_os_cnt == c_OS_LAST) ? '0 : r_os_cnt + 1'b1;
      if (w_tick && (r_os_cnt == c_OS_S0)) r_s0 <= r_rx_sync;
      if (w_tick && (r_os_cnt == c_OS_S1)) r_s1 <= r_rx_sync;
      if (w_bit_end) begin
        if (r_state == ST_DATA)
          r_bit_cnt <= (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
        else if (r_state == ST_STOP)
          r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_decide) begin
        case (r_state)
          ST_DATA:   r_shift   <= {w_maj, r_shift[DATA_WIDTH-1:1]};
          ST_PARITY: r_par_bad <= (^r_shift) ^ w_maj ^ (PARITY_ODD != 0);
          ST_STOP:   r_frm_err <= w_ferr_final;
          default:   ;
        endcase
      end
    end
  end

  // Output holding register with valid/ready handshake and overrun pulse.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= w_frame_done && r_valid && !rx_ready;
      if (w_load) begin
        r_data  <= r_shift;
        r_perr  <= r_par_bad;
        r_ferr  <= w_ferr_final;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign parity_err  = r_perr;
  assign frame_err   = r_ferr;
  assign overrun_err = r_ovr;
  assign busy        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Purpose : Directed self-checking bench for uart_rx (8E1, 64 pclk per bit).
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int BIT_CYC = 64;

  logic       pclk = 1'b0;
  logic       areset = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun_err, busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_valid = 0;
  int   n_ovr = 0;

  always #5 pclk = ~pclk;

  uart_rx #(
    .DATA_WIDTH (8),
    .OVERSAMPLE (16),
    .BAUD_DIV   (4),
    .PARITY_EN  (1),
    .PARITY_ODD (0),
    .STOP_BITS  (1)
  ) dut (
    .pclk        (pclk),
    .areset      (areset),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: even parity check and stop-bit level.
  function automatic exp_t model(input logic [7:0] d, input logic pbit, input logic stopb);
    exp_t e;
    e.data = d;
    e.perr = (^d) ^ pbit;
    e.ferr = ~stopb;
    return e;
  endfunction

  // Scoreboard consumer: every accepted word is compared against the queue.
  always @(negedge pclk) begin
    if (areset) begin
      if (overrun_err) n_ovr++;
      if (rx_valid && rx_ready) begin
        exp_t e;
        n_valid++;
        chk("word_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(e.data));
          chk("parity_err", 32'(parity_err), 32'(e.perr));
          chk("frame_err", 32'(frame_err), 32'(e.ferr));
        end
      end
    end
  end

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge pclk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb, input int stop_cyc);
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CYC);
    drive_bit(pbit, BIT_CYC);
    drive_bit(stopb, stop_cyc);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge pclk);
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int v0, o0, j;
    exp_t e;

    // Reset state
    repeat (4) @(negedge pclk);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun_err", 32'(overrun_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    areset = 1'b1;
    repeat (BIT_CYC) @(negedge pclk);

    // Clean frame 0xA5
    e = model(8'hA5, 1'b0, 1'b1);
    q.push_back(e);
    send_frame(8'hA5, 1'b0, 1'b1, BIT_CYC);
    drain("drain_A5");
    @(negedge pclk);
    chk("A5_valid_cleared", 32'(rx_valid), 32'd0);

    // Parity error frame 0x3C
    e = model(8'h3C, 1'b1, 1'b1);
    q.push_back(e);
    send_frame(8'h3C, 1'b1, 1'b1, BIT_CYC);
    drain("drain_3C");

    // False start: 12 pclk low pulse
    v0 = n_valid;
    drive_bit(1'b0, 12);
    chk("fs_busy_seen", 32'(busy), 32'd1);
    rx = 1'b1;
    j = 0;
    while (busy && j < BIT_CYC) begin
      @(negedge pclk);
      j++;
    end
    chk("fs_busy_returns", 32'(busy), 32'd0);
    repeat (BIT_CYC) @(negedge pclk);
    chk("fs_no_valid", 32'(n_valid - v0), 32'd0);

    // Framing error 0x81 with line held low, then clean 0x55
    e = model(8'h81, 1'b0, 1'b0);
    q.push_back(e);
    send_frame(8'h81, 1'b0, 1'b0, 200);
    drain("drain_81");
    chk("wait_idle_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (6) @(negedge pclk);
    chk("wait_idle_exit", 32'(busy), 32'd0);
    repeat (BIT_CYC) @(negedge pclk);
    e = model(8'h55, 1'b0, 1'b1);
    q.push_back(e);
    send_frame(8'h55, 1'b0, 1'b1, BIT_CYC);
    drain("drain_55");

    // Overrun: second frame dropped while first word is held
    rx_ready = 1'b0;
    o0 = n_ovr;
    e = model(8'h11, ^8'h11, 1'b1);
    q.push_back(e);
    send_frame(8'h11, ^8'h11, 1'b1, BIT_CYC);
    send_frame(8'h22, ^8'h22, 1'b1, BIT_CYC);
    repeat (8) @(negedge pclk);
    chk("ovr_valid_held", 32'(rx_valid), 32'd1);
    chk("ovr_data_held", 32'(rx_data), 32'h11);
    chk("ovr_pulse_count", 32'(n_ovr - o0), 32'd1);
    rx_ready = 1'b1;
    drain("drain_11");
    @(negedge pclk);
    chk("ovr_valid_cleared", 32'(rx_valid), 32'd0);

    // Reset during data bit 4 of 0xFF
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT_CYC);
    drive_bit(1'b1, 30);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    areset = 1'b0;
    @(negedge pclk);
    chk("mid_rst_rx_data", 32'(rx_data), 32'd0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_flags", 32'({parity_err, frame_err, overrun_err}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge pclk);
    areset = 1'b1;
    repeat (2 * BIT_CYC) @(negedge pclk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    e = model(8'h0F, 1'b0, 1'b1);
    q.push_back(e);
    send_frame(8'h0F, 1'b0, 1'b1, BIT_CYC);
    drain("drain_0F");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
